rgb_win_crop: RTL and testbench
===============================

RGB_WIN_CROP -- requirements
Module: rgb_win_crop

Interface
REQ-001 The block SHALL have parameter RAW_HPIXEL, default 11'd1936, meaning input pixels per line.
REQ-002 The block SHALL have parameter RAW_VPIXEL, default 11'd1088, meaning input lines per frame.
REQ-003 The block SHALL have parameter OUT_HPIXEL, default 11'd640, meaning window width.
REQ-004 The block SHALL have parameter OUT_VPIXEL, default 11'd480, meaning window height.
REQ-005 The block SHALL have parameter WIN_X, default 11'd500, meaning window left column (static offset).
REQ-006 The block SHALL have parameter WIN_Y, default 11'd500, meaning window top line (static offset).
REQ-007 The block SHALL have port clk, input, 1 bit, meaning clock for all logic.
REQ-008 The block SHALL have port rstn, input, 1 bit, meaning asynchronous active-low reset.
REQ-009 The block SHALL have port in_href, input, 1 bit, meaning in_rgb carries a valid pixel this cycle.
REQ-010 The block SHALL have port in_rgb, input, 24 bits, meaning demosaiced pixel packed {B,G,R}.
REQ-011 The block SHALL have port win_x, input, 11 bits, meaning runtime left column (only with WIN_CROP_DYN_EN).
REQ-012 The block SHALL have port win_y, input, 11 bits, meaning runtime top line (only with WIN_CROP_DYN_EN).
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning out_rgb holds a windowed pixel.
REQ-014 The block SHALL have port out_rgb, output, 24 bits, meaning windowed pixel, {B,G,R} unchanged.
REQ-015 The block SHALL have port out_sof, output, 1 bit, meaning first window pixel of a frame.
REQ-016 The block SHALL have port out_eol, output, 1 bit, meaning last window pixel of a line.
REQ-017 The block SHALL have port frame_done, output, 1 bit, meaning last input pixel of a frame was consumed.

Function
REQ-018 The block SHALL keep 11-bit h_cnt/v_cnt, advancing only on in_href; h wraps at RAW_HPIXEL-1, v increments on h wrap and wraps at RAW_VPIXEL-1 with h.
REQ-019 The block SHALL use active offsets ax/ay, loaded at reset and when the frame wraps (h=RAW_HPIXEL-1, v=RAW_VPIXEL-1, in_href=1); never mid-frame.
REQ-020 The block SHALL clamp loaded offsets: ax=min(x, RAW_HPIXEL-OUT_HPIXEL), ay=min(y, RAW_VPIXEL-OUT_VPIXEL).
REQ-021 The block SHALL run vertical FSM V_PRE->V_ACT when a line ends with next v==ay, V_ACT->V_POST when line v==ay+OUT_VPIXEL-1 ends, V_POST/any->V_PRE on frame wrap; ay==0 enters V_ACT directly on wrap.
REQ-022 The block SHALL treat a pixel as windowed when in_href=1, FSM in V_ACT, and ax<=h_cnt<=ax+OUT_HPIXEL-1.
REQ-023 The block SHALL register outputs with latency exactly 1 clk from in_href; out_valid asserts for windowed pixels only.
REQ-024 The block SHALL drive out_rgb=24'd0 whenever out_valid=0.
REQ-025 The block SHALL pulse out_sof with the pixel at (ax,ay), and out_eol with each pixel at h=ax+OUT_HPIXEL-1 in V_ACT.
REQ-026 The block SHALL pulse frame_done one cycle, 1 clk after the wrapping pixel, regardless of window.
REQ-027 The block SHALL hold all counters, FSM and outputs' valid low during in_href=0 gaps of any length; no pixel is dropped or duplicated.

Reset
REQ-028 The block SHALL on rstn=0 clear h_cnt, v_cnt, out_valid, out_rgb, out_sof, out_eol, frame_done to 0 and set FSM to V_PRE (V_ACT if loaded ay==0).
REQ-029 The block SHALL, on reset mid-frame, restart at pixel (0,0) on the next in_href after release.

Configuration
REQ-030 The block SHALL, with WIN_CROP_DYN_EN defined, expose win_x/win_y and load ax/ay from them per REQ-019.
REQ-031 The block SHALL, without WIN_CROP_DYN_EN, omit win_x/win_y and load ax/ay from WIN_X/WIN_Y.

Verification (RAW 16x8, OUT 4x2, WIN 3,2 unless stated)
REQ-032 Bench SHALL stream a full frame with continuous in_href -> 8 out_valid pixels, cols 3..6 lines 2..3, 1-clk latency, one out_sof, two out_eol.
REQ-033 Bench SHALL insert random in_href gaps -> identical output pixel sequence and count as continuous case.
REQ-034 Bench SHALL drive win_x=14 (dyn) -> clamped ax=12, pixels cols 12..15; win_x change mid-frame takes effect next frame only.
REQ-035 Bench SHALL end frame -> frame_done single pulse 1 clk after pixel (15,7); two frames back-to-back -> two pulses, 128 clks apart.
REQ-036 Bench SHALL assert rstn low at pixel (5,2) -> all outputs 0 immediately; next frame from (0,0) yields full 8-pixel window.

Source files
------------

// File: rtl/rgb_win_crop.sv
// Static/dynamic rectangular crop of a demosaiced {B,G,R} pixel stream.
// Define WIN_CROP_DYN_EN to take the window offset from win_x/win_y instead of WIN_X/WIN_Y.
module rgb_win_crop #(
    parameter logic [10:0] RAW_HPIXEL = 11'd1936,
    parameter logic [10:0] RAW_VPIXEL = 11'd1088,
    parameter logic [10:0] OUT_HPIXEL = 11'd640,
    parameter logic [10:0] OUT_VPIXEL = 11'd480,
    parameter logic [10:0] WIN_X      = 11'd500,
    parameter logic [10:0] WIN_Y      = 11'd500
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_href,
    input  logic [23:0] in_rgb,
`ifdef WIN_CROP_DYN_EN
    input  logic [10:0] win_x,
    input  logic [10:0] win_y,
`endif
    output logic        out_valid,
    output logic [23:0] out_rgb,
    output logic        out_sof,
    output logic        out_eol,
    output logic        frame_done
);

    localparam logic [1:0] V_PRE  = 2'd0;
    localparam logic [1:0] V_ACT  = 2'd1;
    localparam logic [1:0] V_POST = 2'd2;

    localparam logic [10:0] MAX_X = RAW_HPIXEL - OUT_HPIXEL;
    localparam logic [10:0] MAX_Y = RAW_VPIXEL - OUT_VPIXEL;

    logic [10:0] src_x, src_y, ld_x, ld_y;
`ifdef WIN_CROP_DYN_EN
    assign src_x = win_x;
    assign src_y = win_y;
`else
    assign src_x = WIN_X;
    assign src_y = WIN_Y;
`endif
    assign ld_x = (src_x > MAX_X) ? MAX_X : src_x;
    assign ld_y = (src_y > MAX_Y) ? MAX_Y : src_y;

    logic [10:0] h_cnt, v_cnt, ax_q, ay_q, ax, ay, x_last, y_last;
    logic [1:0]  state_q, st, st_nxt;
    logic        first, h_end, f_end, win;

    // Until the first pixel after reset, offsets track the source so a
    // reset-time load needs no non-constant async reset value.
    assign ax = first ? ld_x : ax_q;
    assign ay = first ? ld_y : ay_q;
    assign st = first ? ((ld_y == 11'd0) ? V_ACT : V_PRE) : state_q;

    assign x_last = ax + OUT_HPIXEL - 11'd1;
    assign y_last = ay + OUT_VPIXEL - 11'd1;
    assign h_end  = (h_cnt == RAW_HPIXEL - 11'd1);
    assign f_end  = h_end && (v_cnt == RAW_VPIXEL - 11'd1);
    assign win    = in_href && (st == V_ACT) && (h_cnt >= ax) && (h_cnt <= x_last);

    always_comb begin
        st_nxt = st;
        if (in_href && h_end) begin
            if (f_end)
                st_nxt = (ld_y == 11'd0) ? V_ACT : V_PRE;
            else begin
                case (st)
                    V_PRE:   if (v_cnt + 11'd1 == ay) st_nxt = V_ACT;
                    V_ACT:   if (v_cnt == y_last)     st_nxt = V_POST;
                    default: st_nxt = st;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt      <= 11'd0;
            v_cnt      <= 11'd0;
            ax_q       <= 11'd0;
            ay_q       <= 11'd0;
            first      <= 1'b1;
            state_q    <= V_PRE;
            out_valid  <= 1'b0;
            out_rgb    <= 24'd0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q <= st_nxt;
            if (first || (in_href && f_end)) begin
                ax_q <= ld_x;
                ay_q <= ld_y;
            end
            if (in_href) begin
                first <= 1'b0;
                if (h_end) begin
                    h_cnt <= 11'd0;
                    v_cnt <= f_end ? 11'd0 : v_cnt + 11'd1;
                end else begin
                    h_cnt <= h_cnt + 11'd1;
                end
            end
            out_valid  <= win;
            out_rgb    <= win ? in_rgb : 24'd0;
            out_sof    <= win && (h_cnt == ax) && (v_cnt == ay);
            out_eol    <= win && (h_cnt == x_last);
            frame_done <= in_href && f_end;
        end
    end

endmodule

// File: tb/tb_rgb_win_crop.sv
// Randomized-data bench for rgb_win_crop on a 16x8 raster with a 4x2 window at (3,2).
// Build with WIN_CROP_DYN_EN defined to also exercise the runtime offset ports.
module tb_rgb_win_crop;

    localparam int RH = 16, RV = 8, OH = 4, OV = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_href;
    logic [23:0] in_rgb;
`ifdef WIN_CROP_DYN_EN
    logic [10:0] win_x, win_y;
`endif
    logic        out_valid, out_sof, out_eol, frame_done;
    logic [23:0] out_rgb;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int nval, nsof, neol;
    int fd_times[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rgb_win_crop #(
        .RAW_HPIXEL(11'd16), .RAW_VPIXEL(11'd8),
        .OUT_HPIXEL(11'd4),  .OUT_VPIXEL(11'd2),
        .WIN_X(11'd3),       .WIN_Y(11'd2)
    ) dut (
        .clk(clk), .rstn(rstn), .in_href(in_href), .in_rgb(in_rgb),
`ifdef WIN_CROP_DYN_EN
        .win_x(win_x), .win_y(win_y),
`endif
        .out_valid(out_valid), .out_rgb(out_rgb), .out_sof(out_sof),
        .out_eol(out_eol), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rgb"},   32'(out_rgb),   32'd0);
        chk({tag, "_sof"},   32'(out_sof),   32'd0);
        chk({tag, "_eol"},   32'(out_eol),   32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    endtask

    // One input pixel at raster (x,y), preceded by up to maxgap idle cycles.
    task automatic pix(input int x, input int y, input int ax, input int ay, input int maxgap);
        int g;
        logic [23:0] d;
        logic w;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            in_href = 1'b0;
            in_rgb  = 24'($urandom);
            @(posedge clk); #1;
            chk_idle("gap");
        end
        d = 24'($urandom);
        in_href = 1'b1;
        in_rgb  = d;
        w = (x >= ax) && (x < ax + OH) && (y >= ay) && (y < ay + OV);
        @(posedge clk); #1;
        in_href = 1'b0;
        chk("pix_valid", 32'(out_valid), 32'(w));
        chk("pix_rgb",   32'(out_rgb),   32'(w ? d : 24'd0));
        chk("pix_sof",   32'(out_sof),   32'(w && x == ax && y == ay));
        chk("pix_eol",   32'(out_eol),   32'(w && x == ax + OH - 1));
        chk("pix_fdone", 32'(frame_done), 32'(x == RH - 1 && y == RV - 1));
        if (out_valid === 1'b1) nval++;
        if (out_sof === 1'b1) nsof++;
        if (out_eol === 1'b1) neol++;
        if (frame_done === 1'b1) fd_times.push_back(cyc);
    endtask

    // Full frame; chg_y >= 0 retargets the runtime offset when that line starts.
    task automatic frame(input int ax, input int ay, input int maxgap, input int chg_y,
                         input int nx, input int ny);
        nval = 0; nsof = 0; neol = 0;
        for (int y = 0; y < RV; y++)
            for (int x = 0; x < RH; x++) begin
`ifdef WIN_CROP_DYN_EN
                if (y == chg_y && x == 0) begin
                    win_x = 11'(nx);
                    win_y = 11'(ny);
                end
`endif
                pix(x, y, ax, ay, maxgap);
            end
        chk("frame_npix", 32'(nval), 32'(OH * OV));
        chk("frame_nsof", 32'(nsof), 32'd1);
        chk("frame_neol", 32'(neol), 32'(OV));
    endtask

    initial begin
        rstn    = 1'b0;
        in_href = 1'b0;
        in_rgb  = 24'd0;
`ifdef WIN_CROP_DYN_EN
        win_x = 11'd3;
        win_y = 11'd2;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rstn = 1'b1;

        // Two continuous back-to-back frames, then one with random gaps.
        frame(3, 2, 0, -1, 0, 0);
        frame(3, 2, 0, -1, 0, 0);
        chk("fdone_count", 32'(fd_times.size()), 32'd2);
        if (fd_times.size() >= 2)
            chk("fdone_spacing", 32'(fd_times[1] - fd_times[0]), 32'd128);
        frame(3, 2, 3, -1, 0, 0);
        frame(3, 2, 1, -1, 0, 0);

        // Reset asserted while pixel (5,2) is on the bus.
        for (int y = 0; y <= 2; y++)
            for (int x = 0; x < RH; x++)
                if (y < 2 || x < 5) pix(x, y, 3, 2, 0);
        in_href = 1'b1;
        in_rgb  = 24'($urandom);
        rstn    = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(posedge clk); #1;
        in_href = 1'b0;
        chk_idle("hold_reset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        frame(3, 2, 2, -1, 0, 0);

`ifdef WIN_CROP_DYN_EN
        // Offset change mid-frame lands on the following frame, clamped to 12,6.
        frame(3, 2, 0, 4, 14, 7);
        frame(12, 6, 2, -1, 0, 0);
        frame(12, 6, 0, 0, 3, 2);
        frame(3, 2, 0, -1, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
